// File: rtl/regfile_onehot.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_onehot
//  Purpose  : 32-entry register file addressed by one-hot selects, with a
//             hardwired-zero register, write-first bypass and sticky
//             malformed-select error reporting.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_onehot #(
  parameter int DW       = 64,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREG-1:0] asel,
  input  logic [NREG-1:0] bsel,
  input  logic [NREG-1:0] dsel,
  input  logic            wr_en,
  input  logic [DW-1:0]   dbus,
  output logic [DW-1:0]   abus,
  output logic [DW-1:0]   bbus,
  output logic            sel_err,
  output logic [7:0]      err_cnt
);

  localparam logic [NREG-1:0] c_ONE      = {{(NREG-1){1'b0}}, 1'b1};
  localparam logic [7:0]      c_CNT_MAX  = 8'hFF;

  // A select is well-formed only when exactly one bit is set.
  function automatic logic f_onehot(input logic [NREG-1:0] v);
    return (v != '0) && ((v & (v - c_ONE)) == '0);
  endfunction

  logic            w_a_ok;
  logic            w_b_ok;
  logic            w_d_ok;
  logic            w_wr_go;
  logic            w_byp_a;
  logic            w_byp_b;
  logic            w_err;
  logic [DW-1:0]   w_rd [NREG];
  logic [DW-1:0]   w_a_mux;
  logic [DW-1:0]   w_b_mux;
  logic            r_sel_err;
  logic [7:0]      r_err_cnt;

  assign w_a_ok  = f_onehot(asel);
  assign w_b_ok  = f_onehot(bsel);
  assign w_d_ok  = f_onehot(dsel);

  // Writes to the zero register fall through naturally: it has no storage.
  assign w_wr_go = wr_en & w_d_ok;

  // Bypass only for a real write to a storage register; reset blocks it.
  assign w_byp_a = w_wr_go & ~reset & w_a_ok & ~dsel[ZERO_REG] & (asel == dsel);
  assign w_byp_b = w_wr_go & ~reset & w_b_ok & ~dsel[ZERO_REG] & (bsel == dsel);

  assign w_err   = ~w_a_ok | ~w_b_ok | (wr_en & ~w_d_ok);

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign w_rd[i] = '0;
    end else begin : g_store
      logic [DW-1:0] r_q;
      // Entry i captures dbus when it is the validated write target.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_q <= '0;
        end else if (w_wr_go && dsel[i]) begin
          r_q <= dbus;
        end
      end
      assign w_rd[i] = r_q;
    end
  end

  // AND-OR read mux over the one-hot selects; the result is only used when
  // the select is well-formed, so multi-hot overlap never reaches a port.
  always_comb begin
    w_a_mux = '0;
    w_b_mux = '0;
    for (int i = 0; i < NREG; i++) begin
      if (asel[i]) w_a_mux = w_a_mux | w_rd[i];
      if (bsel[i]) w_b_mux = w_b_mux | w_rd[i];
    end
  end

  assign abus = !w_a_ok ? '0 : (w_byp_a ? dbus : w_a_mux);
  assign bbus = !w_b_ok ? '0 : (w_byp_b ? dbus : w_b_mux);

  // Sticky error flag and saturating count of erroneous cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_err) begin
      r_sel_err <= 1'b1;
      if (r_err_cnt != c_CNT_MAX) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign sel_err = r_sel_err;
  assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_onehot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_onehot
//  Purpose  : Directed, table-driven self-checking bench for regfile_onehot.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_onehot;

  localparam int DW = 64;

  logic          clk;
  logic          reset;
  logic [31:0]   asel;
  logic [31:0]   bsel;
  logic [31:0]   dsel;
  logic          wr_en;
  logic [DW-1:0] dbus;
  logic [DW-1:0] abus;
  logic [DW-1:0] bbus;
  logic          sel_err;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;

  regfile_onehot #(.DW(DW), .NREG(32), .ZERO_REG(31)) dut (
    .clk     (clk),
    .reset   (reset),
    .asel    (asel),
    .bsel    (bsel),
    .dsel    (dsel),
    .wr_en   (wr_en),
    .dbus    (dbus),
    .abus    (abus),
    .bbus    (bbus),
    .sel_err (sel_err),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   d;
    logic          wr;
    logic [DW-1:0] db;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic          eerr;
    logic [7:0]    ecnt;
  } vec_t;

  localparam int NV = 18;
  vec_t v [NV];

  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic wr, input logic [63:0] db);
    reset = r; asel = a; bsel = b; dsel = d; wr_en = wr; dbus = db;
  endtask

  // One clock: inputs applied now, edge, then settle 1 time unit after it.
  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] d, input logic wr, input logic [63:0] db);
    drive(r, a, b, d, wr, db);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected outputs are the values seen before the edge of that row.
    v[0]  = '{32'd1<<5,  32'd1<<31, 32'd0,     1'b0, 64'h0,  64'h0,  64'h0,  1'b0, 8'd0};
    v[1]  = '{32'd1<<5,  32'd1<<6,  32'd1<<7,  1'b1, DEAD,   64'h0,  64'h0,  1'b0, 8'd0};
    v[2]  = '{32'd1<<7,  32'd1<<7,  32'd0,     1'b0, 64'h0,  DEAD,   DEAD,   1'b0, 8'd0};
    v[3]  = '{32'd1<<31, 32'd1<<7,  32'd1<<31, 1'b1, '1,     64'h0,  DEAD,   1'b0, 8'd0};
    v[4]  = '{32'd1<<31, 32'd1<<0,  32'd0,     1'b0, 64'h0,  64'h0,  64'h0,  1'b0, 8'd0};
    v[5]  = '{32'd1<<4,  32'd1<<4,  32'd1<<3,  1'b1, 64'h11, 64'h0,  64'h0,  1'b0, 8'd0};
    v[6]  = '{32'd1<<3,  32'd1<<4,  32'd0,     1'b0, 64'h0,  64'h11, 64'h0,  1'b0, 8'd0};
    v[7]  = '{32'd1<<3,  32'd1<<4,  32'd1<<3,  1'b1, 64'h22, 64'h22, 64'h0,  1'b0, 8'd0};
    v[8]  = '{32'd1<<3,  32'd1<<3,  32'd0,     1'b0, 64'h0,  64'h22, 64'h22, 1'b0, 8'd0};
    v[9]  = '{32'd1<<10, 32'd1<<10, 32'd1<<10, 1'b1, 64'h33, 64'h33, 64'h33, 1'b0, 8'd0};
    v[10] = '{32'd1<<10, 32'd1<<10, 32'd1<<10, 1'b0, 64'h44, 64'h33, 64'h33, 1'b0, 8'd0};
    v[11] = '{32'd1<<0,  32'd1<<1,  32'h3,     1'b1, 64'h99, 64'h0,  64'h0,  1'b0, 8'd0};
    v[12] = '{32'd1<<0,  32'd1<<1,  32'd0,     1'b0, 64'h0,  64'h0,  64'h0,  1'b1, 8'd1};
    v[13] = '{32'd1<<3,  32'd1<<7,  32'd0,     1'b0, 64'h0,  64'h22, DEAD,   1'b1, 8'd1};
    v[14] = '{32'd0,     32'd1<<3,  32'd0,     1'b0, 64'h0,  64'h0,  64'h22, 1'b1, 8'd1};
    v[15] = '{32'h18,    32'd0,     32'd0,     1'b0, 64'h0,  64'h0,  64'h0,  1'b1, 8'd2};
    v[16] = '{32'd0,     32'd1<<3,  32'd0,     1'b1, 64'h0,  64'h0,  64'h22, 1'b1, 8'd3};
    v[17] = '{32'd1<<3,  32'd1<<7,  32'd0,     1'b0, 64'h0,  64'h22, DEAD,   1'b1, 8'd4};

    // Initial reset, two edges.
    drive(1'b1, 32'd1<<5, 32'd1<<31, 32'd0, 1'b0, 64'h0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(1'b0, v[i].a, v[i].b, v[i].d, v[i].wr, v[i].db);
      #1;
      chk($sformatf("v%0d_abus", i), abus, v[i].ea);
      chk($sformatf("v%0d_bbus", i), bbus, v[i].eb);
      chk($sformatf("v%0d_sel_err", i), {63'd0, sel_err}, {63'd0, v[i].eerr});
      chk($sformatf("v%0d_err_cnt", i), {56'd0, err_cnt}, {56'd0, v[i].ecnt});
      @(posedge clk);
      #1;
    end

    // Reset clears storage and the error state.
    cyc(1'b1, 32'd1<<3, 32'd1<<7, 32'd0, 1'b0, 64'h0);
    drive(1'b0, 32'd1<<3, 32'd1<<7, 32'd0, 1'b0, 64'h0);
    #1;
    chk("rst_reg3", abus, 64'h0);
    chk("rst_reg7", bbus, 64'h0);
    chk("rst_sel_err", {63'd0, sel_err}, 64'd0);
    chk("rst_err_cnt", {56'd0, err_cnt}, 64'd0);

    // Multi-hot bsel for three edges.
    drive(1'b0, 32'd1<<5, 32'h3, 32'd0, 1'b0, 64'h0);
    #1;
    chk("mh_bbus", bbus, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("mh3_sel_err", {63'd0, sel_err}, 64'd1);
    chk("mh3_err_cnt", {56'd0, err_cnt}, 64'd3);

    // Approach and hold saturation.
    repeat (251) @(posedge clk);
    #1;
    chk("sat_254", {56'd0, err_cnt}, 64'd254);
    @(posedge clk);
    #1;
    chk("sat_255", {56'd0, err_cnt}, 64'd255);
    repeat (48) @(posedge clk);
    #1;
    chk("sat_hold", {56'd0, err_cnt}, 64'd255);
    chk("sat_sel_err", {63'd0, sel_err}, 64'd1);

    // Reset priority over a same-cycle write; bypass suppressed during reset.
    cyc(1'b0, 32'd1<<9, 32'd1<<9, 32'd1<<9, 1'b1, 64'h77);
    drive(1'b1, 32'd1<<9, 32'd1<<9, 32'd1<<9, 1'b1, 64'h55);
    #1;
    chk("rp_nobyp_a", abus, 64'h77);
    chk("rp_nobyp_b", bbus, 64'h77);
    @(posedge clk);
    #1;
    drive(1'b0, 32'd1<<9, 32'd1<<9, 32'd0, 1'b0, 64'h0);
    #1;
    chk("rp_reg9", abus, 64'h0);
    chk("rp_sel_err", {63'd0, sel_err}, 64'd0);
    chk("rp_err_cnt", {56'd0, err_cnt}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_onehot.md
Name: regfile_onehot

Overview:
- 32-entry general-purpose register file for the pipelined LEGv8-style datapath.
- Sits in the decode stage directly downstream of the Rn/Rm/Rd field decoders.
- Consumes their 32-bit one-hot selects:
  - asel from the Rn decoder
  - bsel from the Rm decoder
  - dsel from the write-back Rd decoder
- Drives operands abus/bbus into the ID/EX pipeline register.
- Register 31 (XZR) is hardwired to zero.

Parameters:
- DW, 64, register data width in bits.
- NREG, 32, number of registers; fixed to the one-hot select width.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- asel  input  32  one-hot read select, port A (Rn).
- bsel  input  32  one-hot read select, port B (Rm).
- dsel  input  32  one-hot write select (Rd from write-back).
- wr_en  input  1  write enable from write-back stage.
- dbus  input  DW  write data.
- abus  output  DW  read data, port A.
- bbus  output  DW  read data, port B.
- sel_err  output  1  sticky flag: a malformed select was presented.
- err_cnt  output  8  saturating count of cycles with a malformed select.

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high.
- Reset:
  - On a rising clk edge with reset=1, registers 0..30 clear to 0, sel_err to 0, err_cnt to 0.
  - Reset has priority over a same-cycle write.
  - abus and bbus read 0 in the cycle after reset.
- Write:
  - Occurs at a rising edge when reset=0, wr_en=1 and dsel is exactly one-hot.
  - Writes dbus to the register selected by dsel.
  - A write to index ZERO_REG is discarded silently; it is not an error.
  - wr_en=0 means no write, regardless of dsel.
- Read:
  - Combinational, zero-cycle latency.
  - abus = reg[index(asel)]; bbus = reg[index(bsel)].
  - Index ZERO_REG always reads 0.
- Write-first bypass:
  - Applies when, in the same cycle, wr_en=1, dsel is one-hot, dsel != ZERO_REG, and dsel == asel (or bsel).
  - The matching port returns dbus combinationally, before the edge.
  - Both ports may bypass at once.
  - Reset=1 suppresses bypass; reads return stored or zero values.
- Malformed select (popcount != 1; all-zero or multi-hot):
  - On asel or bsel: the affected read port outputs 0.
  - On dsel with wr_en=1: no register changes.
  - Error detection: any malformed asel or bsel, or malformed dsel while wr_en=1.
  - On each rising edge with an error and reset=0: sel_err sets to 1 and stays set until reset; err_cnt increments by 1 and saturates at 255 (no wrap).
  - Multiple simultaneous malformed selects count as 1 per cycle.
- Storage is 31 x DW flops; there is no storage for ZERO_REG.
- Implementation is synthesizable, with no latches and no x-propagation out of abus/bbus after reset.

Test Plan:
- Reset, then asel=1<<5, bsel=1<<31 -> abus=0, bbus=0, sel_err=0, err_cnt=0.
- Write reg 7:
  - Cycle 1: dsel=1<<7, dbus=64'hDEAD_BEEF_0123_4567, wr_en=1 for one edge.
  - Cycle 2: asel=bsel=1<<7 -> abus=bbus=64'hDEAD_BEEF_0123_4567.
- Write XZR: dsel=1<<31, dbus=64'hFFFF..., wr_en=1, then asel=1<<31 -> abus=0, sel_err=0.
- Bypass: reg 3 holds 64'h11.
  - Same cycle: dsel=asel=1<<3, dbus=64'h22, wr_en=1 -> abus=64'h22 before the edge; 64'h22 after.
  - bsel=1<<4 is unaffected.
- Malformed select: bsel=32'h0000_0003 for 3 edges -> bbus=0, sel_err=1, err_cnt=3.
  - Then 300 further malformed cycles -> err_cnt=255.
- Reset priority: reset=1 with wr_en=1, dsel=1<<9, dbus=64'h55 -> after the edge reg 9 reads 0, err_cnt=0, sel_err=0.
